// File: rtl/pc_branch_pkg.sv
// Shared definitions for the PC / branch unit: opcode encoding and the
// location of the opcode field inside the instruction word.
package pc_branch_pkg;

  localparam int unsigned OPC_W  = 3;
  // Opcode bit positions, counted down from the instruction MSB
  // (OPC_HI = 0 is the MSB itself). The top converts them to absolute indices.
  localparam int unsigned OPC_HI = 0;
  localparam int unsigned OPC_LO = OPC_W - 1;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 3'b000,
    OP_JMP  = 3'b001,
    OP_BEQ  = 3'b010,
    OP_BNE  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_BLT  = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Bounded LIFO of return addresses.
// Ports: clk, rst_n (async active-low, clears occupancy only), push_i, pop_i,
//        din_i (address to push), top_o (current top entry), count_o
//        (occupancy), full_o, empty_o.
// A push when full or a pop when empty is ignored.
module pc_ret_stack #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned W     = 5,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     din_i,
  output logic [W-1:0]     top_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next free slot is at count; the top lives one below it.
  assign wr_idx  = IDX_W'(count_q);
  assign rd_idx  = IDX_W'(count_q - CNT_W'(1));
  assign top_o   = mem_q[rd_idx];
  assign count_o = count_q;

  // Occupancy update; push wins if both are ever requested.
  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is not reset: entries above the occupancy are never read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= din_i;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter and branch unit: registered PC, control-flow decode,
// operand compare and a bounded return-address stack.
// Ports: clk, reset (async active-low), instr_valid, instr, r1, r2 (inputs);
//        pc, taken, halted, ras_count, ras_ovf, ras_unf (registered outputs).
// Build option: define PC_BRANCH_BLT_EN to execute opcode 110 as a signed
// less-than branch; otherwise it behaves as NOP.
module pc_branch_unit
  import pc_branch_pkg::*;
#(
  parameter  int unsigned PC_W      = 5,
  parameter  int unsigned DATA_W    = 5,
  parameter  int unsigned INSTR_W   = 19,
  parameter  int unsigned RAS_DEPTH = 4,
  parameter  int unsigned RESET_PC  = 0,
  localparam int unsigned CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  r1,
  input  logic [DATA_W-1:0]  r2,
  output logic [PC_W-1:0]    pc,
  output logic               taken,
  output logic               halted,
  output logic [CNT_W-1:0]   ras_count,
  output logic               ras_ovf,
  output logic               ras_unf
);

  opcode_e         opc;
  logic [PC_W-1:0] target, seq, ras_top;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d, halted_q, halted_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            accept, push, pop, full, empty, blt_hit;
  logic            unused_instr_bits;

  // Decode: only the opcode and the low target bits carry meaning.
  assign opc    = opcode_e'(instr[INSTR_W-1-OPC_HI : INSTR_W-1-OPC_LO]);
  assign target = instr[PC_W-1:0];
  assign seq    = pc_q + PC_W'(1);
  assign accept = instr_valid && !halted_q;
  assign unused_instr_bits = ^instr;

`ifdef PC_BRANCH_BLT_EN
  assign blt_hit = $signed(r1) < $signed(r2);
`else
  assign blt_hit = 1'b0;
`endif

  pc_ret_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (seq),
    .top_o   (ras_top),
    .count_o (ras_count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Next-PC mux and flag updates for an accepted instruction.
  always_comb begin
    pc_d     = pc_q;
    taken_d  = taken_q;
    halted_d = halted_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    push     = 1'b0;
    pop      = 1'b0;
    if (accept) begin
      pc_d    = seq;
      taken_d = 1'b0;
      case (opc)
        OP_JMP: begin
          pc_d    = target;
          taken_d = 1'b1;
        end
        OP_BEQ: if (r1 == r2) begin
          pc_d    = target;
          taken_d = 1'b1;
        end
        OP_BNE: if (r1 != r2) begin
          pc_d    = target;
          taken_d = 1'b1;
        end
        OP_CALL: if (!full) begin
          push    = 1'b1;
          pc_d    = target;
          taken_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        OP_RET: if (!empty) begin
          pop     = 1'b1;
          pc_d    = ras_top;
          taken_d = 1'b1;
        end else begin
          unf_d = 1'b1;
        end
        OP_BLT: if (blt_hit) begin
          pc_d    = target;
          taken_d = 1'b1;
        end
        OP_HALT: begin
          pc_d     = pc_q;
          halted_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= PC_W'(RESET_PC);
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      taken_q  <= taken_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign pc      = pc_q;
  assign taken   = taken_q;
  assign halted  = halted_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule
